muldiv_unit: RTL and testbench

Iterative multiply/divide function unit implementing the RV32M operations, parametrised in operand width. It sits beside the single-cycle ALU/shifter function unit in the execute stage. It takes operands under a start/busy/done handshake, runs a radix-2 shift-add multiplier or restoring divider for XLEN cycles, and holds the result and Z/N flags until the next accepted operation. Divide-by-zero and signed-overflow cases bypass the iteration.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle for the iterative multiply/divide unit.
// master: start/op/A/B/flush out; slave: busy/done/Result/Z/N out.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;
    logic            Z;
    logic            N;

    modport master (
        output start, op, A, B, flush,
        input  busy, done, Result, Z, N
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, done, Result, Z, N
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Ports: clk, reset (sync, active-high), bus (muldiv_unit_if.slave).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic              r_sa;
    logic              r_sb;
    logic              r_spec;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_spec_res;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_bzero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN:0]     w_msum;
    logic [2*XLEN-1:0] w_mul_step;
    logic [XLEN:0]     w_rem_s;
    logic [XLEN:0]     w_dtrial;
    logic [2*XLEN-1:0] w_div_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept = bus.start & ~bus.flush &
                      ((r_state == S_IDLE) | (r_state == S_DONE));

    // Operand signedness by funct3
    assign w_a_sgn = bus.A[XLEN-1] &
                     ((bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                      (bus.op == OP_DIV)  | (bus.op == OP_REM));
    assign w_b_sgn = bus.B[XLEN-1] &
                     ((bus.op == OP_MULH) | (bus.op == OP_DIV) |
                      (bus.op == OP_REM));
    assign w_a_abs = w_a_sgn ? -bus.A : bus.A;
    assign w_b_abs = w_b_sgn ? -bus.B : bus.B;

    // Divide-by-zero and MIN/-1 skip the iteration entirely
    assign w_bzero   = (bus.B == '0);
    assign w_ovf     = ((bus.op == OP_DIV) | (bus.op == OP_REM)) &
                       (bus.A == {1'b1, {(XLEN-1){1'b0}}}) &
                       (&bus.B);
    assign w_special = bus.op[2] & (w_bzero | w_ovf);

    always_comb begin
        w_spec_res = '0;
        if (w_bzero) begin
            w_spec_res = bus.op[1] ? bus.A : '1;
        end else if (w_ovf) begin
            w_spec_res = bus.op[1] ? '0 : bus.A;
        end
    end

    // Multiply: add multiplicand into upper half, shift right with carry
    assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_step = {w_msum, r_acc[XLEN-1:1]};

    // Divide: shift {rem,quot}, keep the trial subtraction if no borrow
    assign w_rem_s    = r_acc[2*XLEN-1:XLEN-1];
    assign w_dtrial   = w_rem_s - {1'b0, r_b};
    assign w_div_step = w_dtrial[XLEN] ?
        {w_rem_s[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
        {w_dtrial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quot = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        if (r_spec) begin
            w_fix_res = r_spec_res;
        end else if (r_op == OP_MUL) begin
            w_fix_res = w_prod[XLEN-1:0];
        end else if (!r_op[2]) begin
            w_fix_res = w_prod[2*XLEN-1:XLEN];
        end else if (!r_op[1]) begin
            w_fix_res = w_quot;
        end else begin
            w_fix_res = w_rem;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    w_next = S_IDLE;
                    if (w_accept) begin
                        w_next = w_special ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(1)) begin
                        w_next = S_FIX;
                    end
                end
                S_FIX: w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= '0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_spec     <= 1'b0;
            r_b        <= '0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_op       <= bus.op;
            r_sa       <= w_a_sgn;
            r_sb       <= w_b_sgn;
            r_spec     <= w_special;
            r_b        <= w_b_abs;
            r_spec_res <= w_spec_res;
            r_acc      <= {{XLEN{1'b0}}, w_a_abs};
            r_cnt      <= CW'(XLEN);
        end else if (!bus.flush) begin
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= r_op[2] ? w_div_step : w_mul_step;
            end else if (r_state == S_FIX) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN) | (r_state == S_FIX);
    assign bus.done   = (r_state == S_DONE);
    assign bus.Result = r_result;
    assign bus.Z      = ~|r_result;
    assign bus.N      = r_result[XLEN-1];
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
// Hand-computed vectors, latency, handshake, flush and reset checks.
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    muldiv_unit_if #(.XLEN(32)) m ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start at a negedge, accept on the following posedge; return at
    // the negedge where done is high (or the bound expires).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output int bc);
        @(negedge clk);
        m.start = 1'b1;
        m.op    = op;
        m.A     = a;
        m.B     = b;
        @(negedge clk);
        m.start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!m.done && lat < 100) begin
            if (m.busy) bc++;
            @(negedge clk);
            lat++;
        end
        res = m.Result;
    endtask

    logic [31:0] res;
    int          lat;
    int          bc;
    int          k;
    int          nd;

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        m.start = 1'b0;
        m.op    = 3'd0;
        m.A     = '0;
        m.B     = '0;
        m.flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", 32'(m.busy), 32'd0);
        check("rst_done", 32'(m.done), 32'd0);
        check("rst_res", m.Result, 32'd0);
        check("rst_z", 32'(m.Z), 32'd1);
        check("rst_n", 32'(m.N), 32'd0);

        do_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, bc);
        check("mul_res", res, 32'hFFFFFFEB);
        check("mul_n", 32'(m.N), 32'd1);
        check("mul_z", 32'(m.Z), 32'd0);
        check("mul_lat", 32'(lat), 32'd34);
        check("mul_busy", 32'(bc), 32'd33);
        @(negedge clk);
        check("mul_pulse", 32'(m.done), 32'd0);

        vecs.push_back('{"mulh", 3'b001, 32'h80000000, 32'h80000000,
                         32'h40000000, 34});
        vecs.push_back('{"mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         32'hFFFFFFFE, 34});
        vecs.push_back('{"mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002,
                         32'hFFFFFFFF, 34});
        vecs.push_back('{"div", 3'b100, 32'hFFFFFFF9, 32'd2,
                         32'hFFFFFFFD, 34});
        vecs.push_back('{"rem", 3'b110, 32'hFFFFFFF9, 32'd2,
                         32'hFFFFFFFF, 34});
        vecs.push_back('{"divu", 3'b101, 32'd100, 32'd7, 32'd14, 34});
        vecs.push_back('{"remu", 3'b111, 32'd100, 32'd7, 32'd2, 34});
        vecs.push_back('{"rem77", 3'b110, 32'd7, 32'd7, 32'd0, 34});
        vecs.push_back('{"divu0", 3'b101, 32'h1234, 32'd0,
                         32'hFFFFFFFF, 2});
        vecs.push_back('{"remu0", 3'b111, 32'h1234, 32'd0, 32'h1234, 2});
        vecs.push_back('{"divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
                         32'h80000000, 2});
        vecs.push_back('{"removf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
                         32'd0, 2});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
            check({vecs[i].tag, "_res"}, res, vecs[i].exp);
            check({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].tag, "_z"}, 32'(m.Z), 32'(vecs[i].exp == 0));
        end

        // start while busy is ignored; start in DONE is accepted
        @(negedge clk);
        m.start = 1'b1;
        m.op    = 3'b000;
        m.A     = 32'd7;
        m.B     = 32'hFFFFFFFD;
        @(negedge clk);
        m.start = 1'b0;
        k = 1;
        repeat (4) @(negedge clk);
        k = 5;
        m.start = 1'b1;
        m.op    = 3'b011;
        m.A     = 32'hFFFFFFFF;
        m.B     = 32'hFFFFFFFF;
        @(negedge clk);
        m.start = 1'b0;
        k = 6;
        while (!m.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ign_res", m.Result, 32'hFFFFFFEB);
        check("ign_lat", 32'(k), 32'd34);
        m.start = 1'b1;
        m.op    = 3'b000;
        m.A     = 32'd3;
        m.B     = 32'd5;
        @(negedge clk);
        m.start = 1'b0;
        k = 1;
        check("b2b_nodone", 32'(m.done), 32'd0);
        while (!m.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("b2b_res", m.Result, 32'd15);
        check("b2b_gap", 32'(k), 32'd34);

        // flush at RUN cycle 10
        @(negedge clk);
        m.start = 1'b1;
        m.op    = 3'b101;
        m.A     = 32'd100;
        m.B     = 32'd7;
        @(negedge clk);
        m.start = 1'b0;
        repeat (9) @(negedge clk);
        m.flush = 1'b1;
        @(negedge clk);
        m.flush = 1'b0;
        check("fl_busy", 32'(m.busy), 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (m.done) nd++;
        end
        check("fl_nodone", 32'(nd), 32'd0);
        check("fl_res", m.Result, 32'd15);

        // reset during RUN
        @(negedge clk);
        m.start = 1'b1;
        m.op    = 3'b100;
        m.A     = 32'hFFFFFFF9;
        m.B     = 32'd2;
        @(negedge clk);
        m.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rr_res", m.Result, 32'd0);
        check("rr_z", 32'(m.Z), 32'd1);
        check("rr_busy", 32'(m.busy), 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (m.done) nd++;
        end
        check("rr_nodone", 32'(nd), 32'd0);

        do_op(3'b000, 32'd3, 32'd5, res, lat, bc);
        check("post_res", res, 32'd15);
        check("post_lat", 32'(lat), 32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
